// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-entry valid/ready output
// register with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] HalfM1 = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            brk_q, brk_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rxs;
  logic            deliver;

  // Synchronizer flops reset to the idle level so reset never looks like a start bit.
  assign rxs = sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    brk_d       = brk_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitM1) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        if (brk_q) begin
          // Line held low after a bad stop bit: wait for idle without re-reporting.
          cnt_d = '0;
          if (rxs) begin
            brk_d   = 1'b0;
            state_d = StIdle;
          end
        end else if (cnt_q == BitM1) begin
          cnt_d = '0;
          if (rxs) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      brk_q       <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      brk_q       <= brk_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule
